// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Types, constants and helpers shared by the FIFO pointer and
//                status blocks.
//                C_PTR_W_DEFAULT : default pointer width (wrap bit included)
//                ptr_t           : pointer type at the default width
//                bin2gray()      : binary to reflected Gray code conversion
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned C_PTR_W_DEFAULT = 10;

    typedef logic [C_PTR_W_DEFAULT-1:0] ptr_t;

    // Adjacent binary codes map to Gray codes that differ in exactly one
    // bit, and the all-ones to zero wrap behaves the same way.
    function automatic ptr_t bin2gray(input ptr_t i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/ptr_bin2gray.sv
`default_nettype none
// ============================================================================
//  Module      : ptr_bin2gray
//  Description : Combinational binary-to-Gray encoder for FIFO pointers.
//                Shared by the write-side and read-side pointer blocks.
//  Ports       : i_bin  [W-1:0] binary pointer value
//                o_gray [W-1:0] Gray-coded value, i_bin ^ (i_bin >> 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module ptr_bin2gray #(
    parameter int unsigned W = 10
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule : ptr_bin2gray
`default_nettype wire

// File: rtl/fifo_write_pointer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_pointer
//  Description : Write-side pointer logic of a synchronous FIFO. It gates
//                producer write requests against the full flag, advances a
//                binary write pointer with a wrap bit, keeps a registered
//                Gray copy of that pointer and flags rejected writes.
//  Ports       : clk         - clock, rising-edge active
//                rst_n       - asynchronous reset, ACTIVE HIGH despite name
//                wr          - write request from producer
//                fifo_full   - full flag from status logic
//                fifo_we     - memory write enable (combinational)
//                wptr        - binary write pointer, MSB is wrap bit
//                wptr_gray   - Gray-coded wptr, registered
//                wr_overflow - one-cycle pulse: write rejected while full
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_pointer
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_W = C_PTR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             fifo_full,
    output logic             fifo_we,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] wptr_gray,
    output logic             wr_overflow
);

    localparam logic [PTR_W-1:0] C_PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_wptr_gray;
    logic             r_wr_overflow;

    logic             w_fifo_we;
    logic [PTR_W-1:0] w_wptr_next;
    logic [PTR_W-1:0] w_wptr_gray_next;

    // The reset term keeps the memory from being written while the pointer
    // is being forced to zero; it takes effect without waiting for a clock.
    assign w_fifo_we = wr & ~fifo_full & ~rst_n;

    // Natural modulo-2^PTR_W wrap: all-ones rolls over to zero and the
    // MSB toggles, which is how full/empty are told apart downstream.
    assign w_wptr_next = w_fifo_we ? (r_wptr + C_PTR_ONE) : r_wptr;

    // Encoding the next value (not the current one) lets the registered
    // Gray output line up with wptr in the same cycle.
    ptr_bin2gray #(
        .W (PTR_W)
    ) u_bin2gray (
        .i_bin  (w_wptr_next),
        .o_gray (w_wptr_gray_next)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wptr        <= '0;
            r_wptr_gray   <= '0;
            r_wr_overflow <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_next;
            r_wptr_gray   <= w_wptr_gray_next;
            // Re-evaluated every edge, so it is a single-cycle pulse per
            // rejected request and never latches.
            r_wr_overflow <= wr & fifo_full;
        end
    end

    assign fifo_we     = w_fifo_we;
    assign wptr        = r_wptr;
    assign wptr_gray   = r_wptr_gray;
    assign wr_overflow = r_wr_overflow;

endmodule : fifo_write_pointer
`default_nettype wire

// File: tb/tb_fifo_write_pointer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_write_pointer
//  Description : Self-checking bench for fifo_write_pointer. A reference
//                model tracks the pointer as a plain integer modulo 2^PTR_W
//                and derives Gray code and overflow from the stated rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_pointer;

    localparam int unsigned PTR_W = 10;
    localparam int unsigned MOD   = 1 << PTR_W;

    logic             clk;
    logic             rst_n;
    logic             wr;
    logic             fifo_full;
    logic             fifo_we;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] wptr_gray;
    logic             wr_overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_ptr     = 0;
    int unsigned m_ov      = 0;
    int unsigned m_writes  = 0;
    int unsigned m_start   = 0;
    logic [PTR_W-1:0] prev_gray;

    fifo_write_pointer #(
        .PTR_W (PTR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .fifo_full   (fifo_full),
        .fifo_we     (fifo_we),
        .wptr        (wptr),
        .wptr_gray   (wptr_gray),
        .wr_overflow (wr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned gray_of(input int unsigned b);
        return (b ^ (b >> 1)) % MOD;
    endfunction

    // One clock cycle: apply inputs, check the combinational enable, take
    // the edge, advance the model and check the registered outputs.
    task automatic step(input logic w, input logic f);
        int unsigned exp_we;
        wr        = w;
        fifo_full = f;
        #1;
        exp_we = (w && !f && !rst_n) ? 1 : 0;
        chk("fifo_we", {31'd0, fifo_we}, exp_we);
        prev_gray = wptr_gray;
        @(posedge clk);
        #1;
        if (rst_n) begin
            m_ptr = 0;
            m_ov  = 0;
        end else begin
            if (exp_we != 0) begin
                m_ptr = (m_ptr + 1) % MOD;
                m_writes++;
            end
            m_ov = (w && f) ? 1 : 0;
        end
        chk("wptr", {22'd0, wptr}, m_ptr);
        chk("wptr_gray", {22'd0, wptr_gray}, gray_of(m_ptr));
        chk("wr_overflow", {31'd0, wr_overflow}, m_ov);
        chk("gray_hamming", ($countones(prev_gray ^ wptr_gray) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        // Reset held with a pending write request
        rst_n     = 1'b1;
        wr        = 1'b1;
        fifo_full = 1'b0;
        #10;
        chk("rst_wptr", {22'd0, wptr}, 0);
        chk("rst_gray", {22'd0, wptr_gray}, 0);
        chk("rst_we", {31'd0, fifo_we}, 0);
        chk("rst_ov", {31'd0, wr_overflow}, 0);
        #2;                      // t=12, between edges
        rst_n = 1'b0;
        wr    = 1'b0;

        // Basic writes: 0->1->2->3, gray 0->1->3->2
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("basic_gray3", {22'd0, wptr_gray}, 2);
        step(1'b0, 1'b0);
        chk("hold_wptr", {22'd0, wptr}, 3);

        // Full blocking then release
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("full_hold", {22'd0, wptr}, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("after_full", {22'd0, wptr}, 5);

        // Idle while full
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Asynchronous reset between edges mid-burst
        step(1'b1, 1'b0);
        #3;
        rst_n = 1'b1;
        #1;
        chk("async_wptr", {22'd0, wptr}, 0);
        chk("async_gray", {22'd0, wptr_gray}, 0);
        chk("async_we", {31'd0, fifo_we}, 0);
        m_ptr = 0;
        m_ov  = 0;
        step(1'b1, 1'b0);        // held in reset across an edge
        rst_n = 1'b0;

        // Wrap-around: 1023 writes from zero, then one more
        for (int i = 0; i < int'(MOD) - 1; i++) step(1'b1, 1'b0);
        chk("wrap_pre_ptr", {22'd0, wptr}, MOD - 1);
        chk("wrap_pre_gray", {22'd0, wptr_gray}, 32'h200);
        step(1'b1, 1'b0);
        chk("wrap_ptr", {22'd0, wptr}, 0);
        chk("wrap_gray", {22'd0, wptr_gray}, 0);

        // Randomized traffic
        m_writes = 0;
        m_start  = m_ptr;
        for (int i = 0; i < 5000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end
        chk("write_count", {22'd0, wptr}, (m_start + m_writes) % MOD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_write_pointer
`default_nettype wire
